// File: rtl/monobit_pkg.sv
// monobit_pkg: shared state, bias-mode and LFSR tap definitions for the monobit stream source
package monobit_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;
    localparam logic [1:0] BIAS_RAW     = 2'b00;
    localparam logic [1:0] BIAS_QUARTER = 2'b01;
    localparam logic [1:0] BIAS_ONES    = 2'b10;
    localparam logic [1:0] BIAS_ZEROS   = 2'b11;
    // taps at bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] LFSR16_TAPS = 16'h002D;
endpackage

// File: rtl/monobit_stream_gen_if.sv
// monobit_stream_gen_if: serial valid/ready bit stream with end-of-block marker
interface monobit_stream_gen_if;
    logic bit_out;
    logic bit_valid;
    logic bit_ready;
    logic last;
    modport master (output bit_out, bit_valid, last, input bit_ready);
    modport slave (input bit_out, bit_valid, last, output bit_ready);
endinterface

// File: rtl/monobit_lfsr16.sv
// monobit_lfsr16: 16-bit Fibonacci LFSR with zero-safe seed load and advance enable
module monobit_lfsr16
    import monobit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic        raw
);
    logic [15:0] l;
    always_ff @(posedge clk)
        if (!rst_n) l <= SEED;
        else if (load) l <= (seed == '0) ? 16'd1 : seed;
        else if (adv) l <= {^(l & LFSR16_TAPS), l[15:1]};
    assign raw = l[0];
endmodule

// File: rtl/monobit_stream_gen.sv
// monobit_stream_gen: emits block_len LFSR-derived bits over valid/ready, with bias modes
// and a tally of transferred ones.
module monobit_stream_gen
    import monobit_pkg::*;
#(
    parameter int LFSR_W = 16,
    parameter int LEN_W = 12,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic [LEN_W-1:0]    block_len,
    input  logic [1:0]          bias_mode,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    monobit_stream_gen_if.master stream,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    ones_count
);
    gen_state_t state;
    logic [LEN_W-1:0] idx, len;
    logic [1:0] mode;
    logic raw, run, xfer;
    assign run = state == RUN;
    assign busy = run;
    assign done = state == DONE;
    assign stream.bit_valid = ena && run;
    assign xfer = stream.bit_valid && stream.bit_ready;
    assign stream.last = run && (idx == len - 1'b1);
    assign stream.bit_out = run && (mode == BIAS_ONES
        || (mode == BIAS_RAW && raw)
        || (mode == BIAS_QUARTER && (raw || idx[1:0] == 2'd3)));
    // the LFSR only moves on transfers so every bias mode walks the same sequence
    monobit_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (ena && state == IDLE && seed_load),
        .adv  (xfer),
        .seed (seed),
        .raw  (raw)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            len        <= '0;
            mode       <= BIAS_RAW;
            ones_count <= '0;
        end else if (ena) begin
            case (state)
                IDLE: if (start) begin
                    len        <= block_len;
                    mode       <= bias_mode;
                    idx        <= '0;
                    ones_count <= '0;
                    state      <= (block_len == '0) ? DONE : RUN;
                end
                RUN: if (xfer) begin
                    idx        <= idx + 1'b1;
                    ones_count <= ones_count + LEN_W'(stream.bit_out);
                    if (stream.last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_monobit_stream_gen.sv
// tb_monobit_stream_gen: scoreboard bench; a reference LFSR model queues expected bits per block
module tb_monobit_stream_gen;
    import monobit_pkg::*;
    logic clk = 0, rst_n = 0, ena = 1, start = 0, seed_load = 0;
    logic [11:0] block_len = '0;
    logic [1:0] bias_mode = '0;
    logic [15:0] seed = '0;
    logic busy, done;
    logic [11:0] ones_count;
    monobit_stream_gen_if sif();
    monobit_stream_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .block_len (block_len),
        .bias_mode (bias_mode),
        .seed_load (seed_load),
        .seed      (seed),
        .stream    (sif),
        .busy      (busy),
        .done      (done),
        .ones_count(ones_count)
    );
    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, n_xfer = 0, rc = 0;
    logic [1:0] exp_q[$];
    logic [15:0] mlfsr = 16'hACE1;
    logic rdy_pat = 0, held = 0, held_bit, held_last;
    logic [3:0] pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        sif.bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.bit_ready = rdy_pat ? pat[rc % 4] : 1'b1;
            rc++;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && sif.bit_valid) begin
            if (held) begin
                check("stall_bit", sif.bit_out, held_bit);
                check("stall_last", sif.last, held_last);
            end
            if (sif.bit_ready) begin
                held = 0;
                n_xfer++;
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bit", sif.bit_out, e[1]);
                    check("last", sif.last, e[0]);
                end
            end else begin
                held = 1;
                held_bit = sif.bit_out;
                held_last = sif.last;
            end
        end
    end

    task automatic push_block(input logic [11:0] len, input logic [1:0] mode, input logic ld,
                              input logic [15:0] sd, output int ones);
        logic b;
        if (ld) mlfsr = (sd == 16'd0) ? 16'd1 : sd;
        ones = 0;
        for (int i = 0; i < int'(len); i++) begin
            b = (mode == 2'b10) ? 1'b1 : (mode == 2'b11) ? 1'b0 :
                (mode == 2'b01) ? (mlfsr[0] | (i % 4 == 3)) : mlfsr[0];
            exp_q.push_back({b, i == int'(len) - 1});
            ones += int'(b);
            mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        end
    endtask

    task automatic kick(input logic [11:0] len, input logic [1:0] mode, input logic ld, input logic [15:0] sd);
        block_len = len;
        bias_mode = mode;
        seed_load = ld;
        seed = sd;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        seed_load = 0;
    endtask

    task automatic run_block(input logic [11:0] len, input logic [1:0] mode, input logic ld,
                             input logic [15:0] sd, input int gap_at);
        int ones;
        push_block(len, mode, ld, sd, ones);
        kick(len, mode, ld, sd);
        check("busy_first", busy, len != 0);
        check("valid_first", sif.bit_valid, len != 0);
        for (int c = 0; c < 2000; c++) begin
            if (done || exp_q.size() == 0) break;
            if (c == gap_at) begin
                ena = 0;
                repeat (3) begin
                    #1 check("valid_ena_low", sif.bit_valid, 0);
                    @(posedge clk);
                    #1;
                end
                ena = 1;
                continue;
            end
            @(posedge clk);
            #1;
        end
        check("done_at_end", {done, exp_q.size() == 0}, 2'b11);
        check("valid_in_done", sif.bit_valid, 0);
        check("busy_in_done", busy, 0);
        check("ones", ones_count, ones);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("ones_hold", ones_count, ones);
    endtask

    initial begin
        int ones, base;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", sif.bit_valid, 0);
        check("rst_bit", sif.bit_out, 0);
        check("rst_last", sif.last, 0);
        check("rst_ones", ones_count, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        run_block(12'd4, 2'b00, 1, 16'd1, -1);
        run_block(12'd8, 2'b01, 1, 16'd1, -1);
        run_block(12'd100, 2'b10, 0, 16'd0, -1);
        run_block(12'd100, 2'b11, 0, 16'd0, -1);
        run_block(12'd37, 2'b00, 0, 16'd0, -1);
        run_block(12'd4, 2'b00, 1, 16'd0, -1);
        rdy_pat = 1;
        run_block(12'd4, 2'b00, 1, 16'd1, -1);
        run_block(12'd4, 2'b00, 1, 16'd1, 3);
        run_block(12'd20, 2'b01, 1, 16'h1234, 5);
        rdy_pat = 0;
        run_block(12'd0, 2'b00, 0, 16'd0, -1);
        push_block(12'd10, 2'b00, 0, 16'd0, ones);
        base = n_xfer;
        kick(12'd10, 2'b00, 0, 16'd0);
        for (int c = 0; c < 100 && n_xfer - base < 3; c++) begin
            @(posedge clk);
            #1;
        end
        check("xfers_before_rst", n_xfer - base, 3);
        rst_n = 0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", sif.bit_valid, 0);
        check("mid_rst_bit", sif.bit_out, 0);
        check("mid_rst_last", sif.last, 0);
        check("mid_rst_ones", ones_count, 0);
        check("mid_rst_state", dut.state, IDLE);
        check("mid_rst_lfsr", dut.u_lfsr.l, 16'hACE1);
        exp_q.delete();
        held = 0;
        mlfsr = 16'hACE1;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("post_rst_done", done, 0);
        run_block(12'd10, 2'b00, 0, 16'd0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
